// File: rtl/ag_panel_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | ag_panel_pkg : shared constants and helpers for the panel input block   |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
package ag_panel_pkg;

    localparam logic [1:0] c_rot_rest          = 2'b11;
    localparam int         c_rot_qthresh       = 4;
    localparam int         c_db_cycles_default = 50000;

    // Clockwise successor on the Gray ring 11 -> 01 -> 00 -> 10 -> 11 ({a,b}).
    function automatic logic [1:0] rot_next_cw(input logic [1:0] ab);
        logic [1:0] nxt;
        case (ab)
            2'b11:   nxt = 2'b01;
            2'b01:   nxt = 2'b00;
            2'b00:   nxt = 2'b10;
            default: nxt = 2'b11;
        endcase
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ag_panel_in_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | ag_panel_in_if : raw panel pins in, debounced/decoded panel events out  |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
interface ag_panel_in_if #(
    parameter int N_BTN = 4,
    parameter int N_SW  = 4
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_SW-1:0]  sw_raw;
    logic             rot_a;
    logic             rot_b;
    logic             rot_center;

    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [N_SW-1:0]  sw_level;
    logic             rot_step;
    logic             rot_dir;
    logic             rot_push;
    logic [7:0]       rot_pos;

    modport master (
        output btn_raw, sw_raw, rot_a, rot_b, rot_center,
        input  btn_level, btn_press, btn_release, sw_level,
               rot_step, rot_dir, rot_push, rot_pos
    );

    modport slave (
        input  btn_raw, sw_raw, rot_a, rot_b, rot_center,
        output btn_level, btn_press, btn_release, sw_level,
               rot_step, rot_dir, rot_push, rot_pos
    );
endinterface
`default_nettype wire

// File: rtl/ag_panel_in_debounce.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | ag_debounce : 2-flop synchroniser, hold-time debounce, edge pulses      |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module ag_debounce
    import ag_panel_pkg::*;
#(
    parameter int DB_CYCLES = c_db_cycles_default
) (
    input  logic clk,
    input  logic rst,
    input  logic i_din,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);
    localparam int c_cw = $clog2(DB_CYCLES);

    logic [1:0]      r_sync;
    logic            r_stable;
    logic [c_cw-1:0] r_cnt;
    logic            r_level;
    logic            r_rise;
    logic            r_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync   <= 2'b00;
            r_stable <= 1'b0;
            r_cnt    <= '0;
            r_level  <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_din};
            if (r_sync[1] == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cw'(DB_CYCLES - 1)) begin
                r_stable <= r_sync[1];
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + c_cw'(1);
            end
            // Output stage: level and its edge pulses change in the same cycle.
            r_level <= r_stable;
            r_rise  <= r_stable & ~r_level;
            r_fall  <= ~r_stable & r_level;
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/ag_panel_in.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | ag_panel_in : debounced buttons/switches and optional rotary decoder    |
// | Rotary decoder built only when AG_PANEL_ROT_EN is defined.   Rev 1.0    |
// +-------------------------------------------------------------------------+
module ag_panel_in
    import ag_panel_pkg::*;
#(
    parameter int N_BTN     = 4,
    parameter int N_SW      = 4,
    parameter int DB_CYCLES = c_db_cycles_default
) (
    input  logic          clk,
    input  logic          rst,
    ag_panel_in_if.slave  pins
);
    logic [N_BTN-1:0] w_btn_level;
    logic [N_BTN-1:0] w_btn_press;
    logic [N_BTN-1:0] w_btn_release;
    logic [N_SW-1:0]  w_sw_level;

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
        ag_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk(clk), .rst(rst), .i_din(pins.btn_raw[gi]),
            .o_level(w_btn_level[gi]), .o_rise(w_btn_press[gi]), .o_fall(w_btn_release[gi])
        );
    end

    for (genvar gi = 0; gi < N_SW; gi++) begin : g_sw
        ag_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk(clk), .rst(rst), .i_din(pins.sw_raw[gi]),
            .o_level(w_sw_level[gi]), .o_rise(), .o_fall()
        );
    end

    assign pins.btn_level   = w_btn_level;
    assign pins.btn_press   = w_btn_press;
    assign pins.btn_release = w_btn_release;
    assign pins.sw_level    = w_sw_level;

`ifdef AG_PANEL_ROT_EN
    localparam logic signed [3:0] c_q_pos = 4'(c_rot_qthresh);
    localparam logic signed [3:0] c_q_neg = 4'(-c_rot_qthresh);

    logic              w_a;
    logic              w_b;
    logic              w_push;
    logic [1:0]        w_ab;
    logic              w_cw;
    logic              w_ccw;
    logic signed [3:0] w_delta;
    logic signed [3:0] w_qsum;

    logic [1:0]        r_ab_prev;
    logic signed [2:0] r_q;
    logic              r_step;
    logic              r_dir;
    logic [7:0]        r_pos;

    ag_debounce #(.DB_CYCLES(DB_CYCLES)) u_rot_a (
        .clk(clk), .rst(rst), .i_din(pins.rot_a), .o_level(w_a), .o_rise(), .o_fall()
    );
    ag_debounce #(.DB_CYCLES(DB_CYCLES)) u_rot_b (
        .clk(clk), .rst(rst), .i_din(pins.rot_b), .o_level(w_b), .o_rise(), .o_fall()
    );
    ag_debounce #(.DB_CYCLES(DB_CYCLES)) u_rot_c (
        .clk(clk), .rst(rst), .i_din(pins.rot_center), .o_level(), .o_rise(w_push), .o_fall()
    );

    // A two-bit jump matches neither successor, so it yields no delta.
    always_comb begin
        w_ab    = {w_a, w_b};
        w_cw    = (w_ab == rot_next_cw(r_ab_prev));
        w_ccw   = (r_ab_prev == rot_next_cw(w_ab));
        w_delta = w_cw ? 4'sd1 : (w_ccw ? -4'sd1 : 4'sd0);
        // Evaluated one bit wider so a full detent of +4 is representable.
        w_qsum  = $signed({r_q[2], r_q}) + w_delta;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ab_prev <= c_rot_rest;
            r_q       <= '0;
            r_step    <= 1'b0;
            r_dir     <= 1'b0;
            r_pos     <= 8'd0;
        end else begin
            r_step    <= 1'b0;
            r_ab_prev <= w_ab;
            if (w_cw || w_ccw) begin
                if (w_ab == c_rot_rest) begin
                    r_q <= '0;
                    if (w_qsum == c_q_pos) begin
                        r_step <= 1'b1;
                        r_dir  <= 1'b1;
                        r_pos  <= r_pos + 8'd1;
                    end else if (w_qsum == c_q_neg) begin
                        r_step <= 1'b1;
                        r_dir  <= 1'b0;
                        r_pos  <= r_pos - 8'd1;
                    end
                end else begin
                    r_q <= w_qsum[2:0];
                end
            end
        end
    end

    assign pins.rot_step = r_step;
    assign pins.rot_dir  = r_dir;
    assign pins.rot_push = w_push;
    assign pins.rot_pos  = r_pos;
`else
    assign pins.rot_step = 1'b0;
    assign pins.rot_dir  = 1'b0;
    assign pins.rot_push = 1'b0;
    assign pins.rot_pos  = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ag_panel_in.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_ag_panel_in : randomized + directed bench with a window-based model  |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module tb_ag_panel_in;
    localparam int N_BTN = 4;
    localparam int N_SW  = 4;
    localparam int DB    = 4;
    localparam int NCH   = N_BTN + N_SW + 3;
    localparam int CH_A  = N_BTN + N_SW;
    localparam int CH_B  = N_BTN + N_SW + 1;
    localparam int CH_C  = N_BTN + N_SW + 2;
`ifdef AG_PANEL_ROT_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ag_panel_in_if #(.N_BTN(N_BTN), .N_SW(N_SW)) pins ();
    ag_panel_in #(.N_BTN(N_BTN), .N_SW(N_SW), .DB_CYCLES(DB)) dut (
        .clk(clk), .rst(rst), .pins(pins)
    );

    int passed = 0;
    int total  = 0;
    int step_seen = 0;
    int b1_activity = 0;

    // Reference model state: raw sample history, stable/level per channel.
    bit hist [NCH][DB+2];
    bit stable [NCH];
    bit lvl [NCH];
    bit rise [NCH];
    bit fall [NCH];
    int q = 0;
    int ab_idx = 0;
    bit m_step = 1'b0;
    bit m_dir = 1'b0;
    int m_pos = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        else passed++;
    endtask

    // Ring position of {a,b}: 11=0, 01=1, 00=2, 10=3; clockwise increases.
    function automatic int gidx(input bit a, input bit b);
        case ({a, b})
            2'b11:   return 0;
            2'b01:   return 1;
            2'b00:   return 2;
            default: return 3;
        endcase
    endfunction

    task automatic model_edge();
        bit raw [NCH];
        int cur, d;
        bit old, all_diff;
        for (int i = 0; i < N_BTN; i++) raw[i] = pins.btn_raw[i];
        for (int i = 0; i < N_SW; i++) raw[N_BTN+i] = pins.sw_raw[i];
        raw[CH_A] = pins.rot_a;
        raw[CH_B] = pins.rot_b;
        raw[CH_C] = pins.rot_center;
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                for (int j = 0; j < DB+2; j++) hist[c][j] = 1'b0;
                stable[c] = 1'b0; lvl[c] = 1'b0; rise[c] = 1'b0; fall[c] = 1'b0;
            end
            q = 0; ab_idx = 0; m_step = 1'b0; m_dir = 1'b0; m_pos = 0;
            return;
        end
        // Rotary reacts to the debounced levels as they stood before this edge.
        m_step = 1'b0;
        cur = gidx(lvl[CH_A], lvl[CH_B]);
        d = (cur - ab_idx + 4) % 4;
        if (d == 1 || d == 3) begin
            q += (d == 1) ? 1 : -1;
            if (cur == 0) begin
                if (q == 4) begin
                    m_step = 1'b1; m_dir = 1'b1; m_pos = (m_pos + 1) % 256;
                end else if (q == -4) begin
                    m_step = 1'b1; m_dir = 1'b0; m_pos = (m_pos + 255) % 256;
                end
                q = 0;
            end
        end
        ab_idx = cur;
        // Stable flips once the last DB synchronised samples all disagree with it.
        for (int c = 0; c < NCH; c++) begin
            for (int j = DB+1; j > 0; j--) hist[c][j] = hist[c][j-1];
            hist[c][0] = raw[c];
            old = lvl[c];
            lvl[c]  = stable[c];
            rise[c] = lvl[c] & ~old;
            fall[c] = ~lvl[c] & old;
            all_diff = 1'b1;
            for (int j = 2; j < DB+2; j++) if (hist[c][j] == stable[c]) all_diff = 1'b0;
            if (all_diff) stable[c] = ~stable[c];
        end
    endtask

    task automatic tick();
        logic [31:0] e_bl, e_bp, e_br, e_sl;
        @(posedge clk);
        model_edge();
        #1;
        e_bl = '0; e_bp = '0; e_br = '0; e_sl = '0;
        for (int i = 0; i < N_BTN; i++) begin
            e_bl[i] = lvl[i]; e_bp[i] = rise[i]; e_br[i] = fall[i];
        end
        for (int i = 0; i < N_SW; i++) e_sl[i] = lvl[N_BTN+i];
        chk_eq("btn_level",   32'(pins.btn_level),   e_bl);
        chk_eq("btn_press",   32'(pins.btn_press),   e_bp);
        chk_eq("btn_release", 32'(pins.btn_release), e_br);
        chk_eq("sw_level",    32'(pins.sw_level),    e_sl);
        chk_eq("rot_step",    32'(pins.rot_step),    ROT ? 32'(m_step) : 32'd0);
        chk_eq("rot_dir",     32'(pins.rot_dir),     ROT ? 32'(m_dir) : 32'd0);
        chk_eq("rot_pos",     32'(pins.rot_pos),     ROT ? 32'(m_pos) : 32'd0);
        chk_eq("rot_push",    32'(pins.rot_push),    ROT ? 32'(rise[CH_C]) : 32'd0);
        if (pins.rot_step) step_seen++;
        if (pins.btn_level[1] | pins.btn_press[1] | pins.btn_release[1]) b1_activity++;
    endtask

    task automatic set_ab(input bit a, input bit b, input int n);
        pins.rot_a = a;
        pins.rot_b = b;
        repeat (n) tick();
    endtask

    initial begin
        int ridx, hold;
        rst = 1'b1;
        pins.btn_raw = '0; pins.sw_raw = '0;
        pins.rot_a = 1'b1; pins.rot_b = 1'b1; pins.rot_center = 1'b0;
        repeat (3) tick();
        chk_eq("rst_btn_level", 32'(pins.btn_level), 32'd0);
        chk_eq("rst_rot_pos",   32'(pins.rot_pos),   32'd0);
        rst = 1'b0;
        repeat (10) tick();

        // Held press: level and press appear on the seventh sampled edge (6 cycles on).
        pins.btn_raw[0] = 1'b1;
        repeat (6) tick();
        chk_eq("btn0_level_early", 32'(pins.btn_level[0]), 32'd0);
        tick();
        chk_eq("btn0_level_6", 32'(pins.btn_level[0]), 32'd1);
        chk_eq("btn0_press_6", 32'(pins.btn_press[0]), 32'd1);
        tick();
        chk_eq("btn0_press_once", 32'(pins.btn_press[0]), 32'd0);

        // Short glitch on button 1.
        b1_activity = 0;
        pins.btn_raw[1] = 1'b1;
        repeat (3) tick();
        pins.btn_raw[1] = 1'b0;
        repeat (12) tick();
        chk_eq("glitch_b1_quiet", 32'(b1_activity), 32'd0);

        // Full clockwise detent, then counter-clockwise twice (wrap to 255).
        step_seen = 0;
        set_ab(0, 1, 10); set_ab(0, 0, 10); set_ab(1, 0, 10); set_ab(1, 1, 10);
        chk_eq("cw_steps", 32'(step_seen), ROT ? 32'd1 : 32'd0);
        chk_eq("cw_dir",   32'(pins.rot_dir), ROT ? 32'd1 : 32'd0);
        chk_eq("cw_pos",   32'(pins.rot_pos), ROT ? 32'd1 : 32'd0);
        step_seen = 0;
        set_ab(1, 0, 10); set_ab(0, 0, 10); set_ab(0, 1, 10); set_ab(1, 1, 10);
        chk_eq("ccw_steps", 32'(step_seen), ROT ? 32'd1 : 32'd0);
        chk_eq("ccw_dir",   32'(pins.rot_dir), 32'd0);
        chk_eq("ccw_pos",   32'(pins.rot_pos), 32'd0);
        set_ab(1, 0, 10); set_ab(0, 0, 10); set_ab(0, 1, 10); set_ab(1, 1, 10);
        chk_eq("wrap_pos", 32'(pins.rot_pos), ROT ? 32'd255 : 32'd0);

        // Half detent and an illegal double-bit jump: no steps.
        step_seen = 0;
        set_ab(0, 1, 10); set_ab(1, 1, 10);
        set_ab(0, 0, 10); set_ab(1, 1, 10);
        chk_eq("half_ignored_steps", 32'(step_seen), 32'd0);
        chk_eq("half_ignored_pos",   32'(pins.rot_pos), ROT ? 32'd255 : 32'd0);

        // Reset in the middle of a rotation with switches high.
        step_seen = 0;
        pins.sw_raw = 4'hF;
        set_ab(0, 1, 10); set_ab(0, 0, 10);
        rst = 1'b1;
        repeat (3) tick();
        chk_eq("midrst_sw",  32'(pins.sw_level), 32'd0);
        chk_eq("midrst_pos", 32'(pins.rot_pos),  32'd0);
        rst = 1'b0;
        repeat (6) tick();
        chk_eq("post_rst_sw_early", 32'(pins.sw_level), 32'd0);
        tick();
        chk_eq("post_rst_sw_6", 32'(pins.sw_level), 32'hF);
        set_ab(1, 1, 12);
        chk_eq("post_rst_steps", 32'(step_seen), 32'd0);

        // Randomised traffic: fast toggles on buttons/switches, slow legal rotary walk.
        ridx = 0;
        hold = 10;
        for (int i = 0; i < 900; i++) begin
            for (int b = 0; b < N_BTN; b++)
                if ($urandom_range(0, 7) == 0) pins.btn_raw[b] = ~pins.btn_raw[b];
            for (int s = 0; s < N_SW; s++)
                if ($urandom_range(0, 11) == 0) pins.sw_raw[s] = ~pins.sw_raw[s];
            if ($urandom_range(0, 7) == 0) pins.rot_center = ~pins.rot_center;
            if (hold == 0) begin
                ridx = ($urandom_range(0, 3) != 0) ? (ridx + 1) % 4 : (ridx + 3) % 4;
                case (ridx)
                    0:       begin pins.rot_a = 1'b1; pins.rot_b = 1'b1; end
                    1:       begin pins.rot_a = 1'b0; pins.rot_b = 1'b1; end
                    2:       begin pins.rot_a = 1'b0; pins.rot_b = 1'b0; end
                    default: begin pins.rot_a = 1'b1; pins.rot_b = 1'b0; end
                endcase
                hold = $urandom_range(6, 14);
            end else begin
                hold--;
            end
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ag_panel_in.md
AG_PANEL_IN -- requirements
Module: ag_panel_in

Interface
REQ-001 SHALL have parameter N_BTN, default 4: number of push-button channels (1..16).
REQ-002 SHALL have parameter N_SW, default 4: number of slide-switch channels (1..16).
REQ-003 SHALL have parameter DB_CYCLES, default 50000: debounce hold time in clk cycles (2..2^20).
REQ-004 SHALL have port clk, in, 1: single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst, in, 1: synchronous reset, active-high.
REQ-006 SHALL have port btn_raw, in, N_BTN: asynchronous button pins, 1 = pressed.
REQ-007 SHALL have port sw_raw, in, N_SW: asynchronous switch pins.
REQ-008 SHALL have ports rot_a, rot_b, rot_center, in, 1 each: asynchronous rotary encoder pins.
REQ-009 SHALL have port btn_level, out, N_BTN: debounced button state.
REQ-010 SHALL have ports btn_press and btn_release, out, N_BTN: one-cycle edge pulses.
REQ-011 SHALL have port sw_level, out, N_SW: debounced switch state.
REQ-012 SHALL have ports rot_step (out, 1: one-cycle detent pulse) and rot_dir (out, 1: 1 = clockwise, valid with rot_step).
REQ-013 SHALL have ports rot_push (out, 1: one-cycle pulse on debounced rot_center rising) and rot_pos (out, 8: detent position counter).

Function
REQ-014 Every raw input SHALL pass a 2-flop synchroniser before any other logic.
REQ-015 Each channel SHALL hold a stable bit and a counter: sync == stable clears the counter; otherwise the counter increments; at count DB_CYCLES-1, stable takes the sync value and the counter clears.
REQ-016 A raw level held constant SHALL reach its level output exactly DB_CYCLES+2 cycles after the first clk edge that samples it.
REQ-017 A glitch shorter than DB_CYCLES synchronised cycles SHALL produce no output change.
REQ-018 btn_press[i] / btn_release[i] SHALL be high only in the single cycle in which btn_level[i] first reads 1 / 0.
REQ-019 Rotary decode SHALL use the debounced A/B pair as a 2-bit Gray state; the rest (detent) state is 2'b11.
REQ-020 Each valid single-bit transition SHALL add +1 (A leads B, clockwise) or -1 to a signed 3-bit quarter counter q.
REQ-021 A transition with both bits changing SHALL be ignored: q unchanged, no pulse.
REQ-022 On entry to state 11: q == +4 -> rot_step = 1, rot_dir = 1, rot_pos + 1; q == -4 -> rot_step = 1, rot_dir = 0, rot_pos - 1; any other q -> no pulse. In all three cases q clears.
REQ-023 rot_pos SHALL wrap modulo 256 (255 + 1 -> 0, 0 - 1 -> 255).
REQ-024 rot_dir SHALL hold its last value between steps.

Reset
REQ-025 rst SHALL clear all synchronisers, stable bits, counters, q and rot_pos; the rotary state resets to 11.
REQ-026 During and after rst, all outputs SHALL read 0 until the first post-reset update.
REQ-027 An input held active through reset SHALL produce its press pulse DB_CYCLES+2 cycles after rst deasserts.
REQ-028 rst mid-debounce or mid-rotation SHALL discard the partial count, with no pulse.

Configuration
REQ-029 Macro AG_PANEL_ROT_EN defined: the rotary decoder and rot_center debounce SHALL be built as specified.
REQ-030 Macro AG_PANEL_ROT_EN undefined: rot_step, rot_dir, rot_push and rot_pos SHALL be constant 0, rot_* inputs SHALL be unused, and no rotary logic SHALL be synthesised.

Structure
REQ-031 Package ag_panel_pkg SHALL hold the rotary rest-state constant (2'b11), the quarter-count threshold (4) and the default DB_CYCLES.
REQ-032 Sub-module ag_debounce (synchroniser + counter + stable bit + rise/fall pulses, parameter DB_CYCLES) SHALL be instantiated once per channel: N_BTN + N_SW + 3 instances with the macro, N_BTN + N_SW without.

Verification (DB_CYCLES = 4)
REQ-033 btn_raw[0] 0->1, held -> btn_level[0] = 1 and btn_press[0] pulse exactly 6 cycles later; btn_release[0] stays 0.
REQ-034 btn_raw[1] 3-cycle high glitch -> btn_level[1], btn_press[1] and btn_release[1] all stay 0.
REQ-035 A/B sequence 11->01->00->10->11, each step held 10 cycles -> one rot_step with rot_dir = 1, rot_pos 0->1; the reverse sequence -> rot_dir = 0, rot_pos 1->0.
REQ-036 rot_pos = 0 plus one counter-clockwise detent -> rot_pos = 255; a half detent 11->01->11 -> no rot_step; 11->00 -> ignored, q unchanged.
REQ-037 rst asserted mid-rotation at q = 2 with sw_raw = 4'hF -> all outputs 0; sw_level = 4'hF 6 cycles after release; no rot_step.
REQ-038 Build without AG_PANEL_ROT_EN, full clockwise detent -> rot_* outputs stay 0.
